// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/VGA arbiter for a single-port RAM, CPU priority with bounded VGA wait.
// Optional per-requester stall counters are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        vga_req,
  input  logic [11:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [31:0] vga_rdata,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0] cpu_stall_cnt,
  output logic [15:0] vga_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    CPU_WR = 2'd2,
    VGA_RD = 2'd3
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] wait_cnt_r;

  // State register: owner of the access granted in the previous cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: record which requester owns the access granted this cycle
  always_comb begin
    next_state_s = IDLE;
    if (cpu_gnt) begin
      next_state_s = cpu_we ? CPU_WR : CPU_RD;
    end else if (vga_gnt) begin
      next_state_s = VGA_RD;
    end else begin
      next_state_s = IDLE;
    end
  end

  // Outputs: arbitration, RAM mux and read responses
  always_comb begin
    cpu_gnt    = 1'b0;
    vga_gnt    = 1'b0;
    ram_wEn    = 1'b0;
    ram_addr   = 12'd0;
    ram_dataIn = 32'd0;
    cpu_rvalid = 1'b0;
    vga_rvalid = 1'b0;
    // VGA wins only when CPU is idle or VGA has waited its full budget
    if (reset) begin
      cpu_gnt = 1'b0;
      vga_gnt = 1'b0;
    end else if (vga_req && (!cpu_req || (wait_cnt_r == MAX_WAIT_C))) begin
      vga_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else begin
      cpu_gnt = 1'b0;
      vga_gnt = 1'b0;
    end

    if (cpu_gnt) begin
      ram_wEn    = cpu_we;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_wdata;
    end else if (vga_gnt) begin
      ram_wEn    = 1'b0;
      ram_addr   = vga_addr;
      ram_dataIn = 32'd0;
    end else begin
      ram_wEn    = 1'b0;
      ram_addr   = 12'd0;
      ram_dataIn = 32'd0;
    end

    case (state_r)
      CPU_RD:  cpu_rvalid = 1'b1;
      VGA_RD:  vga_rvalid = 1'b1;
      CPU_WR:  cpu_rvalid = 1'b0;
      IDLE:    cpu_rvalid = 1'b0;
      default: cpu_rvalid = 1'b0;
    endcase

    cpu_rdata = cpu_rvalid ? ram_dataOut : 32'd0;
    vga_rdata = vga_rvalid ? ram_dataOut : 32'd0;
  end

  // Wait counter: consecutive VGA denials, saturating at MAX_WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= 4'd0;
    end else if (vga_req && !vga_gnt) begin
      if (wait_cnt_r < MAX_WAIT_C) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= MAX_WAIT_C;
      end
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  // Stall statistics: cycles each requester was pending but not granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_stall_cnt <= 16'd0;
      vga_stall_cnt <= 16'd0;
    end else begin
      if (cpu_req && !cpu_gnt && (cpu_stall_cnt != 16'hFFFF)) begin
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end else begin
        cpu_stall_cnt <= cpu_stall_cnt;
      end
      if (vga_req && !vga_gnt && (vga_stall_cnt != 16'hFFFF)) begin
        vga_stall_cnt <= vga_stall_cnt + 16'd1;
      end else begin
        vga_stall_cnt <= vga_stall_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle-latency RAM model.
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        vga_req;
  logic [11:0] vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic [31:0] vga_rdata;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn, ram_dataOut;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] cpu_stall_cnt, vga_stall_cnt;
`endif

  logic [31:0] mem [0:4095];
  logic        pl_we;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
`ifdef MEM_ARBITER_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt), .vga_stall_cnt(vga_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // RAM model: synchronous write, registered read; bench preload port takes priority
  always @(posedge clock) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock); pl_we = 1'b0;
  endtask

  task automatic test_reset;
    cpu_req = 1'b1; vga_req = 1'b1; cpu_addr = 12'h0AA; vga_addr = 12'h0BB; cpu_we = 1'b1;
    #1;
    checks++; if (cpu_gnt !== 1'b0 || vga_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: cpu=%b vga=%b want 0 0", cpu_gnt, vga_gnt); end
    checks++; if (ram_wEn !== 1'b0 || ram_addr !== 12'h000 || ram_dataIn !== 32'h0) begin errors++; $display("FAIL rst_ram: wen=%b addr=%h din=%h want 0", ram_wEn, ram_addr, ram_dataIn); end
    checks++; if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || vga_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp: crv=%b vrv=%b crd=%h vrd=%h want 0", cpu_rvalid, vga_rvalid, cpu_rdata, vga_rdata); end
    @(negedge clock); cpu_req = 1'b0; vga_req = 1'b0; cpu_we = 1'b0; reset = 1'b0;
  endtask

  task automatic test_cpu_read;
    @(negedge clock); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || vga_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt: cpu=%b vga=%b want 1 0", cpu_gnt, vga_gnt); end
    checks++; if (ram_addr !== 12'h010 || ram_wEn !== 1'b0) begin errors++; $display("FAIL rd_ram: addr=%h wen=%b want 010 0", ram_addr, ram_wEn); end
    @(negedge clock); cpu_req = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: rv=%b data=%h want 1 deadbeef", cpu_rvalid, cpu_rdata); end
    checks++; if (vga_rvalid !== 1'b0) begin errors++; $display("FAIL rd_vga_quiet: vrv=%b want 0", vga_rvalid); end
    @(negedge clock); #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rd_end: rv=%b data=%h want 0 0", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_cpu_write;
    @(negedge clock); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h12345678;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || ram_wEn !== 1'b1 || ram_addr !== 12'h020 || ram_dataIn !== 32'h12345678) begin errors++; $display("FAIL wr_ram: gnt=%b wen=%b addr=%h din=%h want 1 1 020 12345678", cpu_gnt, ram_wEn, ram_addr, ram_dataIn); end
    @(negedge clock); cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL wr_no_resp: rv=%b data=%h want 0 0", cpu_rvalid, cpu_rdata); end
    checks++; if (ram_wEn !== 1'b0 || ram_addr !== 12'h000 || ram_dataIn !== 32'h0) begin errors++; $display("FAIL idle_ram: wen=%b addr=%h din=%h want 0", ram_wEn, ram_addr, ram_dataIn); end
    @(negedge clock); cpu_req = 1'b1; cpu_addr = 12'h020;
    @(negedge clock); cpu_req = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL wr_readback: rv=%b data=%h want 1 12345678", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_fairness;
    logic exp_v, prev_c, prev_v;
    prev_c = 1'b0; prev_v = 1'b0;
    @(negedge clock); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030; vga_req = 1'b1; vga_addr = 12'h040;
    for (int i = 0; i < 15; i++) begin
      exp_v = ((i % 5) == 4);
      #1;
      checks++; if (cpu_gnt !== ~exp_v || vga_gnt !== exp_v) begin errors++; $display("FAIL fair_gnt[%0d]: cpu=%b vga=%b want %b %b", i, cpu_gnt, vga_gnt, ~exp_v, exp_v); end
      checks++; if (ram_addr !== (exp_v ? 12'h040 : 12'h030)) begin errors++; $display("FAIL fair_addr[%0d]: addr=%h want %h", i, ram_addr, exp_v ? 12'h040 : 12'h030); end
      if (i > 0) begin
        checks++; if (cpu_rvalid !== prev_c || vga_rvalid !== prev_v) begin errors++; $display("FAIL fair_rv[%0d]: crv=%b vrv=%b want %b %b", i, cpu_rvalid, vga_rvalid, prev_c, prev_v); end
      end
      prev_c = ~exp_v; prev_v = exp_v;
      @(negedge clock);
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    @(negedge clock); vga_req = 1'b1; vga_addr = 12'h100; cpu_req = 1'b0;
    #1;
    checks++; if (vga_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_addr !== 12'h100 || ram_wEn !== 1'b0 || ram_dataIn !== 32'h0) begin errors++; $display("FAIL b2b_vga_gnt: vg=%b cg=%b addr=%h wen=%b din=%h want 1 0 100 0 0", vga_gnt, cpu_gnt, ram_addr, ram_wEn, ram_dataIn); end
    @(negedge clock); vga_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h101;
    #1;
    checks++; if (vga_rvalid !== 1'b1 || vga_rdata !== 32'hA5A50100) begin errors++; $display("FAIL b2b_vga_data: rv=%b data=%h want 1 a5a50100", vga_rvalid, vga_rdata); end
    checks++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0 || ram_addr !== 12'h101) begin errors++; $display("FAIL b2b_cpu_gnt: gnt=%b rv=%b addr=%h want 1 0 101", cpu_gnt, cpu_rvalid, ram_addr); end
    @(negedge clock); cpu_req = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5A5A0101) begin errors++; $display("FAIL b2b_cpu_data: rv=%b data=%h want 1 5a5a0101", cpu_rvalid, cpu_rdata); end
    checks++; if (vga_rvalid !== 1'b0 || vga_rdata !== 32'h0) begin errors++; $display("FAIL b2b_vga_end: rv=%b data=%h want 0 0", vga_rvalid, vga_rdata); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    logic exp_v;
    @(negedge clock); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; vga_req = 1'b1; vga_addr = 12'h040;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_rv: rv=%b want 1", cpu_rvalid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rv_clear: rv=%b data=%h want 0 0", cpu_rvalid, cpu_rdata); end
    checks++; if (cpu_gnt !== 1'b0 || vga_gnt !== 1'b0 || ram_addr !== 12'h000) begin errors++; $display("FAIL mid_gnt: cg=%b vg=%b addr=%h want 0 0 000", cpu_gnt, vga_gnt, ram_addr); end
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_v = (i == 4);
      #1;
      if (i == 0) begin
        checks++; if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin errors++; $display("FAIL mid_post_rv: crv=%b vrv=%b want 0 0", cpu_rvalid, vga_rvalid); end
      end
      checks++; if (cpu_gnt !== ~exp_v || vga_gnt !== exp_v) begin errors++; $display("FAIL mid_wait[%0d]: cpu=%b vga=%b want %b %b", i, cpu_gnt, vga_gnt, ~exp_v, exp_v); end
      @(negedge clock);
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    @(negedge clock);
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic test_stats;
    @(negedge clock); reset = 1'b1; cpu_req = 1'b0; vga_req = 1'b0;
    #1;
    checks++; if (cpu_stall_cnt !== 16'd0 || vga_stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_rst: cpu=%0d vga=%0d want 0 0", cpu_stall_cnt, vga_stall_cnt); end
    @(negedge clock); reset = 1'b0;
    // VGA drops out once per run so the wait budget never forces a CPU stall
    for (int i = 0; i < 12; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
      vga_req = (i != 4) && (i != 9); vga_addr = 12'h040;
      @(negedge clock);
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    #1;
    checks++; if (vga_stall_cnt !== 16'd10 || cpu_stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_cnt: cpu=%0d vga=%0d want 0 10", cpu_stall_cnt, vga_stall_cnt); end
    @(negedge clock);
  endtask
`endif

  initial begin
    reset = 1'b1; pl_we = 1'b0; pl_addr = 12'h0; pl_data = 32'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h0; cpu_wdata = 32'h0;
    vga_req = 1'b0; vga_addr = 12'h0;
    preload(12'h010, 32'hDEADBEEF);
    preload(12'h100, 32'hA5A50100);
    preload(12'h101, 32'h5A5A0101);
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
